// File: rtl/vga_layer_mixer.sv
// Sprite layer compositor: per-layer region/address generation, 3-stage pipeline,
// priority mixing of HUD, sprite layers and background with shield/damage tints.
module vga_layer_lane #(
    parameter int SPRITE_W     = 128,
    parameter int SPRITE_H     = 128,
    parameter int FLASH_FRAMES = 8,
    parameter int AW           = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic [9:0]    h,
    input  logic [9:0]    v,
    input  logic [9:0]    x_in,
    input  logic [9:0]    y_in,
    input  logic          en_in,
    input  logic          shield_in,
    input  logic          hit,
    output logic [AW-1:0] addr,
    output logic          inreg2,
    output logic          shield,
    output logic          tint
);
    localparam int XB = $clog2(SPRITE_W);
    localparam int YB = $clog2(SPRITE_H);

    logic [9:0]  x_s, y_s;
    logic        en_s;
    logic [3:0]  flash_cnt;
    logic        inreg1;
    logic [10:0] x_end, y_end;
    logic [9:0]  dh, dv;
    logic        in_region;

    // 11-bit ends so a sprite hanging off the right/bottom edge never wraps to 0
    assign x_end     = {1'b0, x_s} + 11'(SPRITE_W);
    assign y_end     = {1'b0, y_s} + 11'(SPRITE_H);
    assign in_region = en_s && (h >= x_s) && ({1'b0, h} < x_end)
                            && (v >= y_s) && ({1'b0, v} < y_end);
    assign dh        = h - x_s;
    assign dv        = v - y_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_s    <= '0;
            y_s    <= '0;
            en_s   <= 1'b0;
            shield <= 1'b0;
        end else if (frame_start) begin
            x_s    <= x_in;
            y_s    <= y_in;
            en_s   <= en_in;
            shield <= shield_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr   <= '0;
            inreg1 <= 1'b0;
            inreg2 <= 1'b0;
        end else begin
            addr   <= in_region ? AW'({dv[YB-1:0], dh[XB-1:0]}) : '0;
            inreg1 <= in_region;
            inreg2 <= inreg1;
        end
    end

    // A hit on the same cycle as frame_start reloads rather than decrements
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flash_cnt <= '0;
        else if (hit)
            flash_cnt <= 4'(FLASH_FRAMES);
        else if (frame_start && flash_cnt != 4'd0)
            flash_cnt <= flash_cnt - 4'd1;
    end

    assign tint = (flash_cnt != 4'd0) && flash_cnt[0];
endmodule

module vga_layer_mixer #(
    parameter int          NUM_LAYERS   = 2,
    parameter int          SPRITE_W     = 128,
    parameter int          SPRITE_H     = 128,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [11:0] SHIELD_RGB   = 12'h595,
    parameter logic [11:0] HIT_RGB      = 12'hF00,
    localparam int         AW           = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bright,
    input  logic [9:0]                 hCount,
    input  logic [9:0]                 vCount,
    input  logic                       frame_start,
    input  logic [NUM_LAYERS*10-1:0]   layer_x,
    input  logic [NUM_LAYERS*10-1:0]   layer_y,
    input  logic [NUM_LAYERS-1:0]      layer_en,
    input  logic [NUM_LAYERS-1:0]      layer_shield,
    input  logic [NUM_LAYERS-1:0]      hit_pulse,
    output logic [NUM_LAYERS*AW-1:0]   layer_addr,
    input  logic [NUM_LAYERS*12-1:0]   layer_pixel,
    input  logic                       overlay_valid,
    input  logic [11:0]                overlay_pixel,
    input  logic [11:0]                bg_pixel,
    output logic [11:0]                rgb
);
    localparam int STAGES = 2;

    logic [STAGES:1]       vld_pipe;
    logic [STAGES:1]       ov_pipe;
    logic [11:0]           ov_pix1, ov_pix2, bg1, bg2;
    logic [NUM_LAYERS-1:0] inreg2, shield, tint;
    logic [11:0]           rgb_next;

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_lane
        vga_layer_lane #(
            .SPRITE_W    (SPRITE_W),
            .SPRITE_H    (SPRITE_H),
            .FLASH_FRAMES(FLASH_FRAMES),
            .AW          (AW)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .frame_start(frame_start),
            .h          (hCount),
            .v          (vCount),
            .x_in       (layer_x[i*10 +: 10]),
            .y_in       (layer_y[i*10 +: 10]),
            .en_in      (layer_en[i]),
            .shield_in  (layer_shield[i]),
            .hit        (hit_pulse[i]),
            .addr       (layer_addr[i*AW +: AW]),
            .inreg2     (inreg2[i]),
            .shield     (shield[i]),
            .tint       (tint[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            ov_pipe  <= '0;
            ov_pix1  <= '0;
            ov_pix2  <= '0;
            bg1      <= '0;
            bg2      <= '0;
            rgb      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], bright};
            ov_pipe  <= {ov_pipe[STAGES-1:1], overlay_valid};
            ov_pix1  <= overlay_pixel;
            ov_pix2  <= ov_pix1;
            bg1      <= bg_pixel;
            bg2      <= bg1;
            rgb      <= rgb_next;
        end
    end

    function automatic logic is_clear(input logic [11:0] p);
        return (p == 12'h00C) || (p == 12'h00D) || (p == 12'h00F);
    endfunction

    // Walk from the lowest priority up so layer 0 is the last writer
    always_comb begin
        rgb_next = bg2;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (inreg2[i] && !is_clear(layer_pixel[i*12 +: 12])) begin
                if (shield[i])
                    rgb_next = SHIELD_RGB;
                else if (tint[i])
                    rgb_next = HIT_RGB;
                else
                    rgb_next = layer_pixel[i*12 +: 12];
            end
        end
        if (ov_pipe[STAGES])
            rgb_next = ov_pix2;
        if (!vld_pipe[STAGES])
            rgb_next = 12'h000;
    end
endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer with a one-cycle-latency sprite ROM model.
module tb_vga_layer_mixer;
    logic        clk = 1'b0, rst = 1'b0, bright = 1'b0, frame_start = 1'b0;
    logic [9:0]  hc = '0, vc = '0;
    logic [19:0] layer_x = '0, layer_y = '0;
    logic [1:0]  layer_en = '0, layer_shield = '0, hit_pulse = '0;
    logic [27:0] layer_addr;
    logic [23:0] layer_pixel = '0;
    logic        overlay_valid = 1'b0;
    logic [11:0] overlay_pixel = '0, bg_pixel = '0, rgb;
    logic [11:0] rom0 = '0, rom1 = '0;
    int          checks = 0, errors = 0;

    vga_layer_mixer dut (
        .clk(clk), .rst(rst), .bright(bright), .hCount(hc), .vCount(vc),
        .frame_start(frame_start), .layer_x(layer_x), .layer_y(layer_y),
        .layer_en(layer_en), .layer_shield(layer_shield), .hit_pulse(hit_pulse),
        .layer_addr(layer_addr), .layer_pixel(layer_pixel),
        .overlay_valid(overlay_valid), .overlay_pixel(overlay_pixel),
        .bg_pixel(bg_pixel), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Sprite ROM: data valid one cycle after the address
    always @(posedge clk) layer_pixel <= {rom1, rom0};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bright = 1'b1; hc = 10'd100; vc = 10'd200; bg_pixel = 12'h0AB;
        #2 rst = 1'b1;
        tick(2);
        chk("reset_rgb", 16'(rgb), 16'h000);
        chk("reset_addr0", 16'(layer_addr[13:0]), 16'd0);

        layer_x[9:0] = 10'd100;  layer_y[9:0] = 10'd200;
        layer_x[19:10] = 10'd300; layer_y[19:10] = 10'd300;
        layer_en = 2'b11; rom0 = 12'h111; rom1 = 12'h222;
        @(negedge clk) rst = 1'b0;
        tick(2);
        chk("rst_release_2edges", 16'(rgb), 16'h000);
        tick(1);
        chk("no_render_before_fs", 16'(rgb), 16'h0AB);
        chk("no_addr_before_fs", 16'(layer_addr[13:0]), 16'd0);

        pulse_fs();
        hc = 10'd100; vc = 10'd200;
        tick(1); chk("addr_origin", 16'(layer_addr[13:0]), 16'd0);
        tick(2); chk("rgb_origin", 16'(rgb), 16'h111);
        hc = 10'd227; vc = 10'd327;
        tick(1); chk("addr_last", 16'(layer_addr[13:0]), 16'd16383);
        tick(2); chk("rgb_last", 16'(rgb), 16'h111);
        hc = 10'd228;
        tick(1); chk("addr_past_right", 16'(layer_addr[13:0]), 16'd0);
        tick(2); chk("rgb_past_right", 16'(rgb), 16'h0AB);

        layer_x[9:0] = 10'd250; layer_y[9:0] = 10'd250;
        hc = 10'd300; vc = 10'd300;
        tick(1); chk("midframe_addr0_held", 16'(layer_addr[13:0]), 16'd0);
        tick(2); chk("midframe_rgb_layer1", 16'(rgb), 16'h222);
        pulse_fs();
        tick(1); chk("moved_addr0", 16'(layer_addr[13:0]), 16'd6450);
        tick(2); chk("overlap_layer0_wins", 16'(rgb), 16'h111);
        rom0 = 12'h00D; tick(3); chk("clear_00D", 16'(rgb), 16'h222);
        rom0 = 12'h00C; tick(3); chk("clear_00C", 16'(rgb), 16'h222);
        rom0 = 12'h00F; rom1 = 12'h00F; tick(3); chk("both_clear_bg", 16'(rgb), 16'h0AB);
        rom1 = 12'h222;
        overlay_valid = 1'b1; overlay_pixel = 12'h7E7;
        tick(3); chk("overlay_wins", 16'(rgb), 16'h7E7);
        bright = 1'b0; tick(3); chk("blank_black", 16'(rgb), 16'h000);
        bright = 1'b1; overlay_valid = 1'b0;

        hit_pulse = 2'b10; tick(1); hit_pulse = 2'b00;
        tick(2); chk("flash_cnt8_plain", 16'(rgb), 16'h222);
        for (int k = 1; k <= 8; k++) begin
            pulse_fs();
            tick(3);
            chk($sformatf("flash_frame%0d", k), 16'(rgb), ((8 - k) % 2 == 1) ? 16'hF00 : 16'h222);
        end
        pulse_fs(); tick(3); chk("flash_expired", 16'(rgb), 16'h222);

        rom0 = 12'h333; layer_shield = 2'b01;
        hit_pulse = 2'b01; frame_start = 1'b1; tick(1);
        hit_pulse = 2'b00; frame_start = 1'b0;
        tick(2); chk("shield_cnt8", 16'(rgb), 16'h595);
        pulse_fs(); tick(3); chk("shield_over_flash", 16'(rgb), 16'h595);
        layer_shield = 2'b00;
        pulse_fs(); tick(3); chk("hit_fs_load_even", 16'(rgb), 16'h333);
        pulse_fs(); tick(3); chk("hit_fs_load_odd", 16'(rgb), 16'hF00);

        layer_en = 2'b10; layer_x[19:10] = 10'd1000; layer_y[19:10] = 10'd0;
        pulse_fs();
        hc = 10'd1023; vc = 10'd10;
        tick(1); chk("edge_addr_1023", 16'(layer_addr[27:14]), 16'd1303);
        tick(2); chk("edge_rgb_1023", 16'(rgb), 16'h222);
        hc = 10'd1000; vc = 10'd127;
        tick(1); chk("edge_addr_bottom", 16'(layer_addr[27:14]), 16'd16256);
        tick(2); chk("edge_rgb_bottom", 16'(rgb), 16'h222);
        hc = 10'd5; vc = 10'd10;
        tick(1); chk("no_wrap_addr", 16'(layer_addr[27:14]), 16'd0);
        tick(2); chk("no_wrap_rgb", 16'(rgb), 16'h0AB);
        hc = 10'd1023; bright = 1'b0;
        tick(3); chk("blank_over_layer", 16'(rgb), 16'h000);
        bright = 1'b1;

        hit_pulse = 2'b10; tick(1); hit_pulse = 2'b00;
        pulse_fs(); tick(3); chk("pre_rst_flash", 16'(rgb), 16'hF00);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_rgb", 16'(rgb), 16'h000);
        chk("rst_async_addr1", 16'(layer_addr[27:14]), 16'd0);
        @(negedge clk) rst = 1'b0;
        pulse_fs(); pulse_fs(); tick(3);
        chk("rst_cleared_flash", 16'(rgb), 16'h222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
